// File: rtl/imm_gen_stage_if.sv
// imm_gen_stage_if
// Bundles the upstream (fetch side) and downstream (execute side) handshakes
// of the immediate-generation stage.
//   in_valid / in_ready   : upstream handshake, one instruction per transfer
//   in_instr / in_pc      : 32-bit instruction word and its XLEN-bit address
//   out_valid / out_ready : downstream handshake
//   out_imm / out_fmt / out_target / out_illegal : decoded result
// Modports:
//   slave  : the stage itself (consumes in_*, produces out_*)
//   master : the environment around the stage (produces in_*, consumes out_*)
interface imm_gen_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic [XLEN-1:0] out_target;
  logic            out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_target, out_illegal
  );
endinterface

// File: rtl/imm_gen_stage.sv
// imm_gen_stage
// Registered, handshaked immediate generator for the RV32I decode path.
// Each accepted instruction is decoded combinationally into a sign-extended
// immediate, a format code, a PC-relative target and an illegal flag, then
// held in a two-entry skid buffer (main + skid) so that in_ready is a pure
// register and never depends combinationally on out_ready.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous, active-low reset (clears valid state only)
//   flush  : synchronous discard of every buffered entry
//   bus    : imm_gen_stage_if.slave carrying both handshakes and data
// Parameter:
//   XLEN   : 32 or 64, width of pc / imm / target
// Optional feature (compile-time macro IMM_GEN_ZICSR_EN):
//   when defined, SYSTEM opcodes with funct3[2]=1 decode as CSR-immediate
//   (fmt 6) with imm = zero-extended rs1 field; otherwise they are I-type.
module imm_gen_stage #(
  parameter int XLEN = 32
) (
  input logic            clk,
  input logic            rst_n,
  input logic            flush,
  imm_gen_stage_if.slave bus
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_CSR = 3'd6;
  localparam logic [2:0] FMT_X   = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] target;
    logic            illegal;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state;
  logic            in_ready_q;
  entry_t          main_q;
  entry_t          skid_q;
  entry_t          dec;

  logic [31:0]     instr;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm;
  logic [2:0]      fmt;
  logic            illegal;
  logic            pcrel;
  logic            zimm;

  logic            main_valid;
  logic            accept;
  logic            pop;

  assign instr      = bus.in_instr;
  assign main_valid = (state != EMPTY);
  assign accept     = bus.in_valid & in_ready_q;
  assign pop        = main_valid & bus.out_ready;

  // Opcode decode. Every recognised opcode ends in 2'b11, so a non-32-bit
  // encoding (instr[1:0] != 2'b11) naturally falls into the default arm.
  always_comb begin
    imm32   = '0;
    fmt     = FMT_X;
    illegal = 1'b1;
    pcrel   = 1'b0;
    zimm    = 1'b0;
    case (instr[6:0])
      7'b0110011: begin
        fmt     = FMT_R;
        illegal = 1'b0;
      end
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111: begin
        fmt     = FMT_I;
        illegal = 1'b0;
        imm32   = {{20{instr[31]}}, instr[31:20]};
      end
      7'b1110011: begin
        fmt     = FMT_I;
        illegal = 1'b0;
        imm32   = {{20{instr[31]}}, instr[31:20]};
`ifdef IMM_GEN_ZICSR_EN
        if (instr[14]) begin
          fmt  = FMT_CSR;
          zimm = 1'b1;
        end
`endif
      end
      7'b0100011: begin
        fmt     = FMT_S;
        illegal = 1'b0;
        imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      7'b1100011: begin
        fmt     = FMT_B;
        illegal = 1'b0;
        pcrel   = 1'b1;
        imm32   = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      7'b0110111: begin
        fmt     = FMT_U;
        illegal = 1'b0;
        imm32   = {instr[31:12], 12'b0};
      end
      7'b0010111: begin
        fmt     = FMT_U;
        illegal = 1'b0;
        pcrel   = 1'b1;
        imm32   = {instr[31:12], 12'b0};
      end
      7'b1101111: begin
        fmt     = FMT_J;
        illegal = 1'b0;
        pcrel   = 1'b1;
        imm32   = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  // Widen to XLEN: signed cast sign-extends for XLEN=64, no-op for 32.
  // JALR is deliberately not PC-relative here since rs1 is unavailable.
  assign imm = zimm ? XLEN'(instr[19:15]) : XLEN'(signed'(imm32));
  assign dec = '{
    imm:     imm,
    fmt:     fmt,
    target:  bus.in_pc + (pcrel ? imm : XLEN'(4)),
    illegal: illegal
  };

  // Buffer occupancy. in_ready is registered and equals "skid not valid",
  // so it only drops when entering FULL and rises when leaving it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) state <= ONE;
        end
        ONE: begin
          if (accept && !pop) begin
            state      <= FULL;
            in_ready_q <= 1'b0;
          end else if (!accept && pop) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state      <= ONE;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state      <= EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Payload registers carry no reset; their contents only matter while the
  // matching valid state says so. A flush cycle may still load them, which
  // is harmless because the state returns to EMPTY.
  always_ff @(posedge clk) begin
    case (state)
      EMPTY: begin
        if (accept) main_q <= dec;
      end
      ONE: begin
        if (accept) begin
          if (pop) main_q <= dec;
          else     skid_q <= dec;
        end
      end
      FULL: begin
        if (pop) main_q <= skid_q;
      end
      default: ;
    endcase
  end

  // Outputs are gated to zero whenever no result is presented.
  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = main_valid;
  assign bus.out_imm     = main_valid ? main_q.imm     : '0;
  assign bus.out_fmt     = main_valid ? main_q.fmt     : 3'd0;
  assign bus.out_target  = main_valid ? main_q.target  : '0;
  assign bus.out_illegal = main_valid ? main_q.illegal : 1'b0;

endmodule

// File: tb/tb_imm_gen_stage.sv
// tb_imm_gen_stage
// Scoreboard bench for imm_gen_stage (XLEN=32). The driver pushes the
// expected result of each instruction into a queue as it is offered; an
// independent monitor compares every presented output to the queue head and
// pops it when the downstream handshake completes. Expected values come from
// directed constants or from an arithmetic reference model of RV32I
// immediate encodings.
module tb_imm_gen_stage;

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic [31:0] target;
    logic        illegal;
  } exp_t;

  logic clk;
  logic rst_n;
  logic flush;
  bit   rdyRandom;
  int   vectors;
  int   errors;
  exp_t expQ[$];

  imm_gen_stage_if #(.XLEN(32)) bus ();

  imm_gen_stage #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: immediates are built from field values with integer
  // weights, then the sign bit is applied by subtracting its full weight.
  function automatic exp_t refModel(input logic [31:0] ins, input logic [31:0] pc);
    exp_t   e;
    longint v;
    longint t;
    bit     rel;
    v   = 0;
    rel = 1'b0;
    e.fmt     = 3'd7;
    e.illegal = 1'b1;
    case (ins[6:0])
      7'b0110011: begin
        e.fmt = 3'd0; e.illegal = 1'b0;
      end
      7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011: begin
        e.fmt = 3'd1; e.illegal = 1'b0;
        v = longint'(ins[31:20]);
        if (ins[31]) v -= 4096;
`ifdef IMM_GEN_ZICSR_EN
        if (ins[6:0] == 7'b1110011 && ins[14]) begin
          e.fmt = 3'd6;
          v = longint'(ins[19:15]);
        end
`endif
      end
      7'b0100011: begin
        e.fmt = 3'd2; e.illegal = 1'b0;
        v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
        if (ins[31]) v -= 4096;
      end
      7'b1100011: begin
        e.fmt = 3'd3; e.illegal = 1'b0; rel = 1'b1;
        v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        if (ins[31]) v -= 4096;
      end
      7'b0110111, 7'b0010111: begin
        e.fmt = 3'd4; e.illegal = 1'b0; rel = (ins[6:0] == 7'b0010111);
        v = longint'(ins[31:12]) * 4096;
        if (ins[31]) v -= 64'sh1_0000_0000;
      end
      7'b1101111: begin
        e.fmt = 3'd5; e.illegal = 1'b0; rel = 1'b1;
        v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        if (ins[31]) v -= 1048576;
      end
      default: v = 0;
    endcase
    t = longint'(pc) + (rel ? v : 64'sd4);
    e.imm    = v[31:0];
    e.target = t[31:0];
    return e;
  endfunction

  function automatic logic [31:0] randInstr();
    logic [6:0]  ops [11];
    logic [31:0] ins;
    ops = '{7'b0110011, 7'b0000011, 7'b0010011, 7'b1100111, 7'b0001111, 7'b1110011,
            7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
    ins = $urandom;
    if ($urandom_range(0, 9) < 8) ins[6:0] = ops[$urandom_range(0, 10)];
    return ins;
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Offers one instruction, waits (bounded) for in_ready, records its
  // expected result and returns just after the accepting edge.
  task automatic applyStimulus(input logic [31:0] ins, input logic [31:0] pc,
                               input exp_t e, output int waits);
    bus.in_valid = 1'b1;
    bus.in_instr = ins;
    bus.in_pc    = pc;
    waits = 0;
    while (!bus.in_ready && waits < 50) begin
      stepCycle();
      waits++;
    end
    if (!bus.in_ready) begin
      checkOutput("accept_timeout", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b0;
      return;
    end
    expQ.push_back(e);
    stepCycle();
    bus.in_valid = 1'b0;
  endtask

  // Monitor: compares whatever is presented against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && !flush) begin
      if (bus.out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_output", 64'd1, 64'd0);
        end else begin
          checkOutput("out_imm",     64'(bus.out_imm),     64'(expQ[0].imm));
          checkOutput("out_fmt",     64'(bus.out_fmt),     64'(expQ[0].fmt));
          checkOutput("out_target",  64'(bus.out_target),  64'(expQ[0].target));
          checkOutput("out_illegal", 64'(bus.out_illegal), 64'(expQ[0].illegal));
          if (bus.out_ready) void'(expQ.pop_front());
        end
      end else begin
        checkOutput("idle_zero",
                    {bus.out_imm, bus.out_target} | 64'(bus.out_fmt) | 64'(bus.out_illegal),
                    64'd0);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdyRandom) bus.out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    int          w;
    logic [31:0] ins;
    logic [31:0] pc;

    rst_n        = 1'b0;
    flush        = 1'b0;
    rdyRandom    = 1'b0;
    vectors      = 0;
    errors       = 0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready",  64'(bus.in_ready),  64'd1);
    checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_outputs",
                {bus.out_imm, bus.out_target} | 64'(bus.out_fmt) | 64'(bus.out_illegal), 64'd0);
    stepCycle();
    rst_n = 1'b1;
    stepCycle();

    // B-type with one-cycle latency
    bus.out_ready = 1'b1;
    applyStimulus(32'hFE000EE3, 32'h100, '{32'hFFFFFFFC, 3'd3, 32'h000000FC, 1'b0}, w);
    checkOutput("latency_b", 64'(bus.out_valid), 64'd1);
    stepCycle();

    // J then U back to back, one per cycle
    applyStimulus(32'h0080006F, 32'h200, '{32'h00000008, 3'd5, 32'h00000208, 1'b0}, w);
    checkOutput("latency_j", 64'(bus.out_valid), 64'd1);
    applyStimulus(32'h123450B7, 32'h204, '{32'h12345000, 3'd4, 32'h00000208, 1'b0}, w);
    checkOutput("throughput_u_wait", 64'(w), 64'd0);
    checkOutput("latency_u", 64'(bus.out_valid), 64'd1);

    // S-type and all-zero illegal word
    applyStimulus(32'hFE20AC23, 32'h300, '{32'hFFFFFFF8, 3'd2, 32'h00000304, 1'b0}, w);
    applyStimulus(32'h00000000, 32'h304, '{32'h00000000, 3'd7, 32'h00000308, 1'b1}, w);

    // CSR immediate, result depends on build option
`ifdef IMM_GEN_ZICSR_EN
    applyStimulus(32'h3002D073, 32'h400, '{32'h00000005, 3'd6, 32'h00000404, 1'b0}, w);
`else
    applyStimulus(32'h3002D073, 32'h400, '{32'h00000300, 3'd1, 32'h00000404, 1'b0}, w);
`endif
    repeat (3) stepCycle();

    // Back-pressure: A, B fill the buffer, C stalls until drain
    bus.out_ready = 1'b0;
    ins = randInstr(); pc = $urandom & ~32'h3;
    applyStimulus(ins, pc, refModel(ins, pc), w);
    ins = randInstr(); pc = $urandom & ~32'h3;
    applyStimulus(ins, pc, refModel(ins, pc), w);
    checkOutput("bp_full_in_ready", 64'(bus.in_ready), 64'd0);
    ins = randInstr(); pc = $urandom & ~32'h3;
    bus.in_valid = 1'b1; bus.in_instr = ins; bus.in_pc = pc;
    repeat (3) stepCycle();
    checkOutput("bp_stall_in_ready", 64'(bus.in_ready), 64'd0);
    bus.out_ready = 1'b1;
    applyStimulus(ins, pc, refModel(ins, pc), w);
    repeat (4) stepCycle();
    checkOutput("bp_drained", 64'(expQ.size()), 64'd0);

    // Flush with the buffer full
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ins = randInstr(); pc = $urandom & ~32'h3;
      applyStimulus(ins, pc, refModel(ins, pc), w);
    end
    flush = 1'b1;
    bus.in_valid = 1'b1; bus.in_instr = randInstr();
    expQ.delete();
    stepCycle();
    flush = 1'b0; bus.in_valid = 1'b0;
    checkOutput("flush_out_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("flush_in_ready",  64'(bus.in_ready),  64'd1);

    // Transfer offered during a flush cycle is dropped
    flush = 1'b1;
    bus.in_valid = 1'b1; bus.in_instr = 32'h0080006F; bus.in_pc = 32'h500;
    stepCycle();
    flush = 1'b0; bus.in_valid = 1'b0;
    checkOutput("flush_drop", 64'(bus.out_valid), 64'd0);
    stepCycle();

    // Asynchronous reset mid-stream
    for (int i = 0; i < 2; i++) begin
      ins = randInstr(); pc = $urandom & ~32'h3;
      applyStimulus(ins, pc, refModel(ins, pc), w);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_valid", 64'(bus.out_valid), 64'd0);
    expQ.delete();
    stepCycle();
    rst_n = 1'b1;
    stepCycle();
    checkOutput("rst_release_in_ready", 64'(bus.in_ready), 64'd1);

    // Randomized traffic with random downstream back-pressure
    rdyRandom = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) stepCycle();
      ins = randInstr();
      pc  = $urandom & ~32'h3;
      applyStimulus(ins, pc, refModel(ins, pc), w);
    end
    rdyRandom = 1'b0;
    #1;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 20 && expQ.size() != 0; n++) stepCycle();
    checkOutput("drain_timeout", 64'(expQ.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
